// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if
//   Bundles the turn sequencer's game-side signals: player count, pick
//   button, card-match strobe, position read-back and the turn/step/winner
//   outputs.
//   slave  : the sequencer (consumes n_players/btn/match/p_pos, drives the rest)
//   master : the surrounding game logic / bench
interface turn_sequencer_if #(
  parameter int MAXP = 4,
  parameter int PW   = 5
);
  logic [3:0]         n_players;
  logic               btn;
  logic               match_valid;
  logic               match_ok;
  logic [MAXP*PW-1:0] p_pos;
  logic [MAXP-1:0]    p_da;
  logic               step;
  logic [1:0]         cur_player;
  logic               win_valid;
  logic [1:0]         win_id;

  modport master (
    output n_players, btn, match_valid, match_ok, p_pos,
    input  p_da, step, cur_player, win_valid, win_id
  );

  modport slave (
    input  n_players, btn, match_valid, match_ok, p_pos,
    output p_da, step, cur_player, win_valid, win_id
  );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer
//   Turn control for the board game: one-hot player enable p_da and a single
//   step pulse per matched pick, capture detection after every step, player
//   elimination and winner declaration.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - turn_sequencer_if.slave (n_players, btn, match_valid, match_ok,
//          p_pos in; p_da, step, cur_player, win_valid, win_id out)
// Optional: define TURN_TIMEOUT_EN to forfeit a turn after TIMEOUT_CYC idle
//   cycles in WAIT_PICK; without it WAIT_PICK waits indefinitely.
//
// state     | meaning
// IDLE      | no game; waiting for a button press with a legal count
// WAIT_PICK | active player enabled, waiting for the pick button
// WAIT_RES  | waiting for the card logic's match result
// STEP      | one-cycle step pulse to the position counters
// SETTLE    | two cycles for the counter output to settle
// CHECK     | compare positions, capture, detect a winner
// NEXT      | advance to the next surviving player
// WIN       | game over, terminal until reset
module turn_sequencer #(
  parameter int MAXP        = 4,
  parameter int PW          = 5,
  parameter int TIMEOUT_CYC = 50000000
) (
  input logic             clk,
  input logic             rst,
  turn_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PICK, S_WAIT_RES, S_STEP, S_SETTLE, S_CHECK, S_NEXT, S_WIN
  } state_t;

  localparam logic [MAXP-1:0] ONE = MAXP'(1);

  state_t          r_state;
  logic [2:0]      r_count;
  logic [MAXP-1:0] r_elim;
  logic [2:0]      r_caps;
  logic            r_settle;
  logic [MAXP-1:0] r_pda;
  logic            r_step;
  logic [1:0]      r_cur;
  logic            r_win_valid;
  logic [1:0]      r_win_id;
  logic            r_btn_s1, r_btn_s2, r_btn_s3;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo;
`endif

  logic            w_btn_ev;
  logic            w_n_legal;
  logic [PW-1:0]   w_cur_pos;
  logic [MAXP-1:0] w_cap;
  logic [2:0]      w_cap_cnt;
  logic [1:0]      w_next;

  assign w_btn_ev  = r_btn_s2 & ~r_btn_s3;
  assign w_n_legal = (bus.n_players >= 4'd2) && (bus.n_players <= 4'd4);
  assign w_cur_pos = bus.p_pos[r_cur*PW +: PW];

  // Opponents still in play that share the active player's square.
  always_comb begin
    w_cap     = '0;
    w_cap_cnt = '0;
    for (int j = 0; j < MAXP; j++) begin
      if (j < int'(r_count) && j != int'(r_cur) && !r_elim[j] &&
          bus.p_pos[j*PW +: PW] == w_cur_pos) begin
        w_cap[j]  = 1'b1;
        w_cap_cnt = w_cap_cnt + 3'd1;
      end
    end
  end

  // Nearest surviving player after r_cur; scanning k downwards lets the
  // smallest offset win.
  always_comb begin
    int idx;
    idx    = 0;
    w_next = r_cur;
    for (int k = MAXP - 1; k >= 1; k--) begin
      idx = int'(r_cur) + k;
      if (idx >= int'(r_count)) idx = idx - int'(r_count);
      if (k < int'(r_count) && !r_elim[2'(idx)]) w_next = 2'(idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_elim      <= '0;
      r_caps      <= '0;
      r_settle    <= 1'b0;
      r_pda       <= '0;
      r_step      <= 1'b0;
      r_cur       <= '0;
      r_win_valid <= 1'b0;
      r_win_id    <= '0;
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
      r_btn_s3    <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      r_btn_s1 <= bus.btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
      r_step   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_pda <= '0;
          if (w_btn_ev && w_n_legal) begin
            r_count <= bus.n_players[2:0];
            r_cur   <= '0;
            r_pda   <= ONE;
            r_elim  <= '0;
            r_caps  <= '0;
            r_state <= S_WAIT_PICK;
`ifdef TURN_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
        end
        S_WAIT_PICK: begin
          if (w_btn_ev) begin
            r_state <= S_WAIT_RES;
          end
`ifdef TURN_TIMEOUT_EN
          else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
            r_state <= S_NEXT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        S_WAIT_RES: begin
          if (bus.match_valid) begin
            if (bus.match_ok) begin
              r_step  <= 1'b1;
              r_state <= S_STEP;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_STEP: begin
          r_settle <= 1'b0;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle) r_state <= S_CHECK;
          else          r_settle <= 1'b1;
        end
        S_CHECK: begin
          r_elim <= r_elim | w_cap;
          r_caps <= r_caps + w_cap_cnt;
          if (r_caps + w_cap_cnt == r_count - 3'd1) begin
            r_win_id    <= r_cur;
            r_win_valid <= 1'b1;
            r_pda       <= '0;
            r_state     <= S_WIN;
          end else begin
            r_state <= S_WAIT_PICK;
`ifdef TURN_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
        end
        S_NEXT: begin
          r_cur   <= w_next;
          r_pda   <= ONE << w_next;
          r_state <= S_WAIT_PICK;
`ifdef TURN_TIMEOUT_EN
          r_tmo   <= '0;
`endif
        end
        S_WIN: begin
          r_pda <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.p_da       = r_pda;
  assign bus.step       = r_step;
  assign bus.cur_player = r_cur;
  assign bus.win_valid  = r_win_valid;
  assign bus.win_id     = r_win_id;
endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;
  localparam int MAXP = 4;
  localparam int PW   = 5;
`ifdef TURN_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 50000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  turn_sequencer_if #(.MAXP(MAXP), .PW(PW)) bus ();
  turn_sequencer #(.MAXP(MAXP), .PW(PW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int step_cycles = 0;

  // Game model: who plays, who is out, who won.
  bit m_play, m_wres, m_won, exp_step;
  int m_cnt, m_cur, m_caps, m_winid, n_sel;
  bit m_elim [4];
  int pos [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task model_reset();
    m_play = 0; m_wres = 0; m_won = 0; exp_step = 0;
    m_cnt = 0; m_cur = 0; m_caps = 0; m_winid = 0;
    for (int i = 0; i < 4; i++) m_elim[i] = 0;
  endtask

  function int next_of(input int c);
    for (int k = 1; k < m_cnt; k++)
      if (!m_elim[(c + k) % m_cnt]) return (c + k) % m_cnt;
    return c;
  endfunction

  task model_btn();
    if (!m_play) begin
      if (n_sel >= 2 && n_sel <= 4) begin
        m_play = 1; m_cnt = n_sel; m_cur = 0; m_caps = 0;
        for (int i = 0; i < 4; i++) m_elim[i] = 0;
      end
    end else if (!m_won && !m_wres) begin
      m_wres = 1;
    end
  endtask

  task model_capture();
    for (int j = 0; j < m_cnt; j++)
      if (j != m_cur && !m_elim[j] && pos[j] == pos[m_cur]) begin
        m_elim[j] = 1;
        m_caps++;
      end
    if (m_caps == m_cnt - 1) begin
      m_won = 1;
      m_winid = m_cur;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("p_da", 32'(bus.p_da), (m_play && !m_won) ? (32'd1 << m_cur) : 32'd0);
      check("step", 32'(bus.step), 32'(exp_step));
      check("cur_player", 32'(bus.cur_player), 32'(m_cur));
      check("win_valid", 32'(bus.win_valid), 32'(m_won));
      check("win_id", 32'(bus.win_id), 32'(m_winid));
      if (bus.step) step_cycles++;
    end
  end

  task tick(); @(negedge clk); endtask

  task set_pos(input int a, input int b, input int c, input int d);
    pos[0] = a; pos[1] = b; pos[2] = c; pos[3] = d;
    for (int i = 0; i < 4; i++) bus.p_pos[i*PW +: PW] = PW'(pos[i]);
  endtask

  task set_n(input int n);
    n_sel = n;
    bus.n_players = 4'(n);
  endtask

  // btn rises; FSM acts on the third rising clock edge afterwards.
  task press();
    bus.btn = 1'b1;
    tick(); tick();
    model_btn();
    tick();
    bus.btn = 1'b0;
    tick(); tick(); tick();
  endtask

  task match(input bit ok);
    bus.match_valid = 1'b1;
    bus.match_ok    = ok;
    if (m_wres) begin
      m_wres = 0;
      if (ok) begin
        exp_step = 1; tick();
        bus.match_valid = 1'b0; exp_step = 0; tick();
        tick(); tick();
        model_capture(); tick();
      end else begin
        tick();
        bus.match_valid = 1'b0; m_cur = next_of(m_cur); tick();
      end
    end else begin
      tick();
      bus.match_valid = 1'b0;
      tick();
    end
  endtask

  task do_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn = 1'b0; bus.match_valid = 1'b0; bus.match_ok = 1'b0;
    set_n(0); set_pos(0, 0, 0, 0);
    model_reset();
    rst = 1'b1;
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_p_da", 32'(bus.p_da), 32'd0);
    check("rst_win_valid", 32'(bus.win_valid), 32'd0);

    // Illegal player counts stay in IDLE.
    set_n(5); press();
    check("illegal5_p_da", 32'(bus.p_da), 32'd0);
    set_n(1); press();
    check("illegal1_p_da", 32'(bus.p_da), 32'd0);

    // Three players: start, miss, match keeps turn, wrap.
    set_n(3); set_pos(0, 3, 9, 15);
    press();
    check("start_p_da", 32'(bus.p_da), 32'h1);
    press(); match(0);
    check("miss_p_da", 32'(bus.p_da), 32'h2);
    check("miss_cur", 32'(bus.cur_player), 32'd1);
    press();
    step_cycles = 0;
    match(1);
    check("step_cycles", 32'(step_cycles), 32'd1);
    check("keep_p_da", 32'(bus.p_da), 32'h2);
    check("keep_cur", 32'(bus.cur_player), 32'd1);
    press(); match(0);
    check("cur_to_2", 32'(bus.cur_player), 32'd2);
    press(); match(0);
    check("wrap_cur", 32'(bus.cur_player), 32'd0);

    // Four players, P2 captured, skip, then a double capture wins.
    do_reset();
    set_n(4); set_pos(7, 1, 7, 12);
    press();
    press(); match(1);
    check("p2_capt_nowin", 32'(bus.win_valid), 32'd0);
    check("p2_capt_cur", 32'(bus.cur_player), 32'd0);
    press(); match(0);
    check("p0_miss_cur", 32'(bus.cur_player), 32'd1);
    press(); match(0);
    check("skip_cur", 32'(bus.cur_player), 32'd3);
    check("skip_p_da", 32'(bus.p_da), 32'h8);
    press(); match(0);
    check("skip_wrap_cur", 32'(bus.cur_player), 32'd0);
    set_pos(12, 12, 7, 12);
    press(); match(1);
    check("dbl_win_valid", 32'(bus.win_valid), 32'd1);
    check("dbl_win_id", 32'(bus.win_id), 32'd0);

    // Two players: P1 wins, later inputs ignored.
    do_reset();
    set_n(2); set_pos(4, 9, 0, 0);
    press();
    press(); match(1);
    check("nocapt_win", 32'(bus.win_valid), 32'd0);
    press(); match(0);
    check("p1_turn", 32'(bus.cur_player), 32'd1);
    set_pos(4, 4, 0, 0);
    press(); match(1);
    check("p1_win_valid", 32'(bus.win_valid), 32'd1);
    check("p1_win_id", 32'(bus.win_id), 32'd1);
    check("p1_win_p_da", 32'(bus.p_da), 32'd0);
    press(); match(1); match(0);
    check("win_sticky", 32'(bus.win_valid), 32'd1);
    check("win_p_da_hold", 32'(bus.p_da), 32'd0);

    // Two players: P0 captures P1 at square 5.
    do_reset();
    set_n(2); set_pos(5, 5, 0, 0);
    press();
    press(); match(1);
    check("p0_win_valid", 32'(bus.win_valid), 32'd1);
    check("p0_win_id", 32'(bus.win_id), 32'd0);

    // Reset during the step pulse.
    do_reset();
    set_n(2); set_pos(1, 2, 0, 0);
    press(); press();
    bus.match_valid = 1'b1; bus.match_ok = 1'b1;
    m_wres = 0; exp_step = 1;
    tick();
    check("pre_rst_step", 32'(bus.step), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_step", 32'(bus.step), 32'd0);
    check("rst_mid_p_da", 32'(bus.p_da), 32'd0);
    check("rst_mid_cur", 32'(bus.cur_player), 32'd0);
    bus.match_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    set_n(3);
    press();
    check("restart_p_da", 32'(bus.p_da), 32'h1);

`ifdef TURN_TIMEOUT_EN
    // Eight idle cycles in WAIT_PICK forfeit the turn.
    tick(); tick(); tick(); tick(); tick();
    m_cur = next_of(m_cur);
    tick();
    check("timeout_cur", 32'(bus.cur_player), 32'd1);
    check("timeout_p_da", 32'(bus.p_da), 32'h2);
`endif

    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Drives the per-player position counters for the board game: produces the one-hot turn enables `p_da` and the `step` advance pulse that each position counter consumes.
- Tracks whose turn it is across 2..4 players, reading the card-match result from the card logic.
- Reads back all player positions after every step to detect captures, eliminate captured players and declare a winner.
- Sits between the button/card logic and the position counters, in the same `clk`/`rst` domain.

Parameters:
- MAXP, 4, maximum number of players; sizes `p_da` and `p_pos`.
- PW, 5, position width per player (board of 24 squares, positions 0..23).
- TIMEOUT_CYC, 50000000, idle cycles in WAIT_PICK before the turn is forfeited; used only with TURN_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- n_players  input  4  player count; legal values are 2, 3 and 4; sampled in IDLE.
- btn  input  1  raw pick button, asynchronous to `clk`.
- match_valid  input  1  one-cycle strobe from the card logic: a pick result is ready.
- match_ok  input  1  pick matched the next tile; qualified by `match_valid`.
- p_pos  input  MAXP*PW  player positions, player i at bits [i*PW +: PW].
- p_da  output  MAXP  one-hot active-player enable to the position counters.
- step  output  1  one-cycle advance pulse; the counters advance on its rising edge.
- cur_player  output  2  index of the active player.
- win_valid  output  1  a winner has been declared; sticky until `rst`.
- win_id  output  2  index of the winning player.

Behaviour:
- Reset values:
  - p_da = 0, step = 0, cur_player = 0, win_valid = 0, win_id = 0.
  - All elimination flags and the capture count are cleared.
  - FSM state is IDLE.
- Reset during any state aborts the turn immediately. `step` drops asynchronously. The position counters share `rst`, so the board restarts.
- `btn` input path:
  - 2-flop synchronizer, then rising-edge detect giving `btn_ev`, one cycle wide.
  - Latency from a btn edge to the FSM seeing it is 3 cycles.
- FSM states:
  - IDLE:
    - p_da = 0.
    - On `btn_ev` with n_players in {2,3,4}: latch n_players, cur_player = 0, go to WAIT_PICK.
    - An illegal count keeps the FSM in IDLE.
  - WAIT_PICK:
    - p_da = one-hot(cur_player).
    - On `btn_ev`, go to WAIT_RES.
    - `match_valid` in this state is ignored.
  - WAIT_RES:
    - On `match_valid` with `match_ok` = 1, go to STEP.
    - On `match_valid` with `match_ok` = 0, go to NEXT.
    - `btn_ev` in this state is ignored.
  - STEP: step = 1 for exactly one cycle, then go to SETTLE.
  - SETTLE: 2 cycles with step = 0, so the counter output is stable; then go to CHECK.
  - CHECK: compare pos[cur] against pos[j] for every j ≠ cur that is below the latched count and not eliminated.
    - Each equal j is eliminated and increments the capture count. Multiple matches in one check are all captured.
    - If captures = count − 1: win_id = cur_player, win_valid = 1, go to WIN.
    - Otherwise return to WAIT_PICK with the same player (a match keeps the turn).
  - NEXT: cur_player becomes the next index, (cur+1) mod count, skipping eliminated players; go to WAIT_PICK. Takes 1 cycle.
  - WIN: p_da = 0, step = 0. Terminal until `rst`.
- `p_da` does not change in the cycle before, during or after a `step` pulse.
- Captures occur only on a step. No position wrap logic is needed here: the counters wrap 23 → 0 themselves.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to WAIT_PICK and increments each cycle in that state.
  - When it reaches TIMEOUT_CYC − 1 with no `btn_ev`, the FSM goes to NEXT and the turn is forfeited.
  - A `btn_ev` in that same cycle takes priority: the FSM goes to WAIT_RES.
- Not defined: the counter logic is absent and WAIT_PICK waits indefinitely.

Test Plan:
- Start and miss: rst, n_players=3, btn edge → WAIT_PICK, p_da=0001. Then btn, match_valid=1, match_ok=0 → no step pulse, p_da=0010, cur_player=1.
- Match and keep turn: cur_player=1, btn, then a match_ok=1 strobe → exactly one 1-cycle step. p_da stays 0010 throughout, and the FSM returns to WAIT_PICK with cur_player still 1.
- Capture: n_players=2, p_pos P0=5, P1=5 after P0's step → win_valid=1, win_id=0, p_da=0, and further btn/match input is ignored.
- Skip and illegal count:
  - n_players=4 with P2 eliminated: a miss by P1 gives cur_player=3, and a miss by P3 gives cur_player=0.
  - With n_players=5, a btn edge leaves the FSM in IDLE with p_da=0.
- Reset mid-step: assert rst in the STEP cycle → step drops the same cycle and all outputs return to reset values. With TURN_TIMEOUT_EN and TIMEOUT_CYC=8, 8 idle cycles in WAIT_PICK → cur_player advances by one.
